// File: rtl/riscv_cpu_core_if.sv
// Program-load port for the RV32I-subset core: lets a host fill instruction
// and data memory word by word before (or while) the core runs.
interface riscv_cpu_core_if;
  logic        load_en;
  logic        load_dmem;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  modport master (output load_en, load_dmem, load_addr, load_data);
  modport slave  (input  load_en, load_dmem, load_addr, load_data);
endinterface

// File: rtl/riscv_cpu_core.sv
// Single-issue RV32I-subset core with identity MMU, 16-line direct-mapped
// write-through cache and 256-word instruction/data memories.
module riscv_cache (
  input  logic        clk,
  input  logic        reset,
  input  logic        access,
  input  logic        load,
  input  logic        store,
  input  logic [3:0]  index,
  input  logic [27:0] addr_tag,
  input  logic [31:0] store_data,
  input  logic [31:0] fill_data,
  output logic        hit,
  output logic        miss,
  output logic [31:0] data_out
);
  logic [31:0] cache_mem [0:15];
  logic [27:0] tag       [0:15];
  logic        valid     [0:15];

  assign hit      = access && valid[index] && (tag[index] == addr_tag);
  assign miss     = load && !hit;
  assign data_out = cache_mem[index];

  // Only valid bits are reset, so an abandoned fill can never leave a live line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) valid[i] <= 1'b0;
    end else if (store || miss) begin
      valid[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (store || miss) begin
      cache_mem[index] <= store ? store_data : fill_data;
      tag[index]       <= addr_tag;
    end
  end
endmodule

module riscv_cpu_core (
  input  logic                    clk,
  input  logic                    reset,
  riscv_cpu_core_if.slave         prog,
  output logic [31:0]             result
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE= 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  logic [31:0] regs [0:31];
  logic [31:0] pc, pc_next, instr;

  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm_i, imm_s, imm_b;
  logic        is_lw, is_sw, is_beq;
  logic        wb_en;
  logic [31:0] wb_data;

  logic [31:0] mmu_virtual_addr, mmu_physical_addr, mmu_data_in;
  logic        mmu_mem_write;
  logic [3:0]  cache_index;
  logic        cache_hit, cache_miss;
  logic [31:0] cache_data_out;
  logic [3:0]  unused_pc;

  assign instr  = imem[pc[9:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign unused_pc = {pc[1:0], pc[31], pc[10]} ^ {2'b00, |pc[30:11], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  assign is_lw  = (opcode == OP_LOAD);
  assign is_sw  = (opcode == OP_STORE);
  assign is_beq = (opcode == OP_BR);

  // Identity translation; addresses are word indices.
  assign mmu_virtual_addr  = rs1_val + (is_sw ? imm_s : imm_i);
  assign mmu_physical_addr = mmu_virtual_addr;
  assign mmu_data_in       = is_sw ? rs2_val : cache_data_out;
  assign mmu_mem_write     = is_sw && !reset;
  assign cache_index       = mmu_virtual_addr[3:0];

  riscv_cache cache_unit (
    .clk        (clk),
    .reset      (reset),
    .access     (is_lw || is_sw),
    .load       (is_lw),
    .store      (mmu_mem_write),
    .index      (cache_index),
    .addr_tag   (mmu_physical_addr[31:4]),
    .store_data (mmu_data_in),
    .fill_data  (dmem[mmu_physical_addr[7:0]]),
    .hit        (cache_hit),
    .miss       (cache_miss),
    .data_out   (cache_data_out)
  );

  // Unrecognised encodings fall through with wb_en low and act as NOPs.
  always_comb begin
    wb_en   = 1'b0;
    wb_data = 32'd0;
    case (opcode)
      OP_R: begin
        wb_en = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: wb_data = rs1_val + rs2_val;
          {7'b0100000, 3'b000}: wb_data = rs1_val - rs2_val;
          {7'b0000000, 3'b111}: wb_data = rs1_val & rs2_val;
          {7'b0000000, 3'b110}: wb_data = rs1_val | rs2_val;
          {7'b0000000, 3'b100}: wb_data = rs1_val ^ rs2_val;
          {7'b0000000, 3'b010}: wb_data = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
          default:              wb_en   = 1'b0;
        endcase
      end
      OP_IMM: begin
        wb_en   = (funct3 == 3'b000);
        wb_data = rs1_val + imm_i;
      end
      OP_LOAD: begin
        wb_en   = cache_hit;
        wb_data = mmu_data_in;
      end
      default: ;
    endcase
  end

  // A load miss holds pc for one cycle while the line fills.
  always_comb begin
    pc_next = pc + 32'd4;
    if (cache_miss)
      pc_next = pc;
    else if (is_beq && (rs1_val == rs2_val))
      pc_next = pc + imm_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= 32'd0;
      result <= 32'd0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc <= pc_next;
      if (wb_en && (rd != 5'd0)) begin
        regs[rd] <= wb_data;
        result   <= wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (prog.load_en && !prog.load_dmem)
      imem[prog.load_addr] <= prog.load_data;
    if (mmu_mem_write)
      dmem[mmu_physical_addr[7:0]] <= mmu_data_in;
    else if (prog.load_en && prog.load_dmem)
      dmem[prog.load_addr] <= prog.load_data;
  end
endmodule

// File: tb/tb_riscv_cpu_core.sv
// Scoreboard bench for riscv_cpu_core: programs are loaded through the load
// port, expected values are queued per cycle and compared at the falling edge.
module tb_riscv_cpu_core;
  logic        clk;
  logic        reset;
  logic [31:0] result;
  int          errors = 0;
  int          checks = 0;

  localparam int S_RESULT = 0, S_PC = 1, S_HIT = 2, S_MISS = 3, S_TAG0 = 4,
                 S_VALID0 = 5, S_CMEM0 = 6, S_DMEM64 = 7, S_MWRITE = 8,
                 S_VALIDANY = 9, S_VALID1 = 10;

  typedef struct {
    string       tag;
    int          cyc;
    int          sel;
    logic [31:0] exp;
  } sb_t;
  sb_t sbq[$];

  riscv_cpu_core_if prog_bus ();

  riscv_cpu_core dut (
    .clk    (clk),
    .reset  (reset),
    .prog   (prog_bus.slave),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] encR(int f7, int rs2, int rs1, int f3, int rd);
    logic [6:0] a; logic [4:0] b, c, e; logic [2:0] d;
    a = f7[6:0]; b = rs2[4:0]; c = rs1[4:0]; d = f3[2:0]; e = rd[4:0];
    return {a, b, c, d, e, 7'b0110011};
  endfunction

  function automatic logic [31:0] encI(int imm, int rs1, int f3, int rd, logic [6:0] op);
    logic [11:0] i; logic [4:0] c, e; logic [2:0] d;
    i = imm[11:0]; c = rs1[4:0]; d = f3[2:0]; e = rd[4:0];
    return {i, c, d, e, op};
  endfunction

  function automatic logic [31:0] encS(int imm, int rs2, int rs1);
    logic [11:0] i; logic [4:0] b, c;
    i = imm[11:0]; b = rs2[4:0]; c = rs1[4:0];
    return {i[11:5], b, c, 3'b010, i[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encB(int imm, int rs2, int rs1);
    logic [12:0] i; logic [4:0] b, c;
    i = imm[12:0]; b = rs2[4:0]; c = rs1[4:0];
    return {i[12], i[10:5], b, c, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] observe(int sel);
    logic any;
    case (sel)
      S_RESULT: return result;
      S_PC:     return dut.pc;
      S_HIT:    return {31'd0, dut.cache_hit};
      S_MISS:   return {31'd0, dut.cache_miss};
      S_TAG0:   return {4'd0, dut.cache_unit.tag[0]};
      S_VALID0: return {31'd0, dut.cache_unit.valid[0]};
      S_CMEM0:  return dut.cache_unit.cache_mem[0];
      S_DMEM64: return dut.dmem[64];
      S_MWRITE: return {31'd0, dut.mmu_mem_write};
      S_VALID1: return {31'd0, dut.cache_unit.valid[1]};
      default: begin
        any = 1'b0;
        for (int i = 0; i < 16; i++) any = any | dut.cache_unit.valid[i];
        return {31'd0, any};
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic toDmem, input int addr, input logic [31:0] data);
    @(negedge clk);
    prog_bus.load_en   = 1'b1;
    prog_bus.load_dmem = toDmem;
    prog_bus.load_addr = addr[7:0];
    prog_bus.load_data = data;
    @(negedge clk);
    prog_bus.load_en   = 1'b0;
  endtask

  task automatic pushExpect(input string tag, input int cyc, input int sel, input logic [31:0] exp);
    sb_t e;
    e.tag = tag; e.cyc = cyc; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Cycle 0 is the falling edge at which reset drops; cycle k follows the k-th rising edge.
  task automatic runScoreboard(input int maxCyc);
    sb_t e;
    for (int c = 0; c <= maxCyc; c++) begin
      while (sbq.size() > 0 && sbq[0].cyc == c) begin
        e = sbq.pop_front();
        checkOutput(e.tag, observe(e.sel), e.exp);
      end
      if (c < maxCyc) @(negedge clk);
    end
    if (sbq.size() != 0) begin
      checkOutput("sb_drain", sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    logic [31:0] a, b;
    reset = 1'b0;
    prog_bus.load_en   = 1'b0;
    prog_bus.load_dmem = 1'b0;
    prog_bus.load_addr = 8'd0;
    prog_bus.load_data = 32'd0;
    #2 reset = 1'b1;

    // ALU program
    a = 32'd100; b = 32'hFFFF_FFFD;
    applyStimulus(0, 0,  encI(100, 0, 0, 1, 7'b0010011));
    applyStimulus(0, 1,  encI(-3, 0, 0, 2, 7'b0010011));
    applyStimulus(0, 2,  encR(0, 2, 1, 0, 3));
    applyStimulus(0, 3,  encR(32, 1, 2, 0, 4));
    applyStimulus(0, 4,  encR(0, 1, 2, 2, 5));
    applyStimulus(0, 5,  encR(0, 2, 1, 7, 6));
    applyStimulus(0, 6,  encR(0, 2, 1, 6, 7));
    applyStimulus(0, 7,  encR(0, 2, 1, 4, 8));
    applyStimulus(0, 8,  encR(0, 2, 1, 2, 9));
    applyStimulus(0, 9,  encI(55, 0, 0, 0, 7'b0010011));
    applyStimulus(0, 10, encR(0, 4, 3, 0, 10));
    applyStimulus(0, 11, 32'h0000_007F);
    pushExpect("rst_result",   0, S_RESULT,   32'd0);
    pushExpect("rst_pc",       0, S_PC,       32'd0);
    pushExpect("rst_valid",    0, S_VALIDANY, 32'd0);
    pushExpect("rst_mwrite",   0, S_MWRITE,   32'd0);
    pushExpect("addi_100",     1, S_RESULT,   a);
    pushExpect("addi_m3",      2, S_RESULT,   b);
    pushExpect("add_97",       3, S_RESULT,   a + b);
    pushExpect("sub",          4, S_RESULT,   b - a);
    pushExpect("slt_true",     5, S_RESULT,   32'd1);
    pushExpect("and",          6, S_RESULT,   a & b);
    pushExpect("or",           7, S_RESULT,   a | b);
    pushExpect("xor",          8, S_RESULT,   a ^ b);
    pushExpect("slt_false",    9, S_RESULT,   32'd0);
    pushExpect("x0_discard",  10, S_RESULT,   32'd0);
    pushExpect("add_neg",     11, S_RESULT,   (a + b) + (b - a));
    pushExpect("nop_result",  12, S_RESULT,   (a + b) + (b - a));
    pushExpect("nop_pc",      12, S_PC,       32'd48);
    releaseReset();
    runScoreboard(12);

    // Memory, cache and branch program
    reset = 1'b1;
    applyStimulus(1, 32, 32'd100);
    applyStimulus(1, 64, 32'd0);
    applyStimulus(1, 97, 32'd1234);
    applyStimulus(0, 0,  encI(32, 0, 0, 5, 7'b0010011));
    applyStimulus(0, 1,  encI(0, 5, 2, 6, 7'b0000011));
    applyStimulus(0, 2,  encI(0, 5, 2, 6, 7'b0000011));
    applyStimulus(0, 3,  encI(500, 0, 0, 8, 7'b0010011));
    applyStimulus(0, 4,  encI(64, 0, 0, 7, 7'b0010011));
    applyStimulus(0, 5,  encS(0, 8, 7));
    applyStimulus(0, 6,  encI(0, 7, 2, 9, 7'b0000011));
    applyStimulus(0, 7,  encI(0, 5, 2, 10, 7'b0000011));
    applyStimulus(0, 8,  encI(0, 7, 2, 11, 7'b0000011));
    applyStimulus(0, 9,  encI(0, 5, 2, 12, 7'b0000011));
    applyStimulus(0, 10, encB(8, 0, 0));
    applyStimulus(0, 11, encI(99, 0, 0, 13, 7'b0010011));
    applyStimulus(0, 12, encI(7, 0, 0, 14, 7'b0010011));
    applyStimulus(0, 13, encB(8, 7, 5));
    applyStimulus(0, 14, encI(-1, 0, 0, 15, 7'b0010011));
    pushExpect("ld_valid_rst",  0, S_VALID0, 32'd0);
    pushExpect("ld_x5",         1, S_RESULT, 32'd32);
    pushExpect("ld1_miss",      1, S_MISS,   32'd1);
    pushExpect("ld1_stall_pc",  2, S_PC,     32'd4);
    pushExpect("ld1_hit2",      2, S_HIT,    32'd1);
    pushExpect("ld1_tag",       2, S_TAG0,   32'd2);
    pushExpect("ld1_valid",     2, S_VALID0, 32'd1);
    pushExpect("ld1_result",    3, S_RESULT, 32'd100);
    pushExpect("ld2_hit",       3, S_HIT,    32'd1);
    pushExpect("ld2_result",    4, S_RESULT, 32'd100);
    pushExpect("ld2_pc",        4, S_PC,     32'd12);
    pushExpect("sw_strobe",     6, S_MWRITE, 32'd1);
    pushExpect("sw_pre_result", 6, S_RESULT, 32'd64);
    pushExpect("sw_dmem",       7, S_DMEM64, 32'd500);
    pushExpect("sw_cmem",       7, S_CMEM0,  32'd500);
    pushExpect("sw_tag",        7, S_TAG0,   32'd4);
    pushExpect("sw_pc",         7, S_PC,     32'd24);
    pushExpect("lw_after_sw",   7, S_HIT,    32'd1);
    pushExpect("lw_sw_result",  8, S_RESULT, 32'd500);
    pushExpect("conf1_miss",    8, S_MISS,   32'd1);
    pushExpect("conf1_tag",     9, S_TAG0,   32'd2);
    pushExpect("conf1_result", 10, S_RESULT, 32'd100);
    pushExpect("conf2_miss",   10, S_MISS,   32'd1);
    pushExpect("conf2_result", 12, S_RESULT, 32'd500);
    pushExpect("conf3_miss",   12, S_MISS,   32'd1);
    pushExpect("conf3_result", 14, S_RESULT, 32'd100);
    pushExpect("beq_pc",       15, S_PC,     32'd48);
    pushExpect("beq_skip",     15, S_RESULT, 32'd100);
    pushExpect("beq_target",   16, S_RESULT, 32'd7);
    pushExpect("bne_pc",       17, S_PC,     32'd56);
    pushExpect("wrap_m1",      18, S_RESULT, 32'hFFFF_FFFF);
    releaseReset();
    runScoreboard(18);

    // Reset in the middle of a miss stall
    reset = 1'b1;
    applyStimulus(0, 0, encI(97, 0, 0, 5, 7'b0010011));
    applyStimulus(0, 1, encI(0, 5, 2, 6, 7'b0000011));
    pushExpect("stall_miss", 1, S_MISS, 32'd1);
    releaseReset();
    runScoreboard(1);
    reset = 1'b1;
    #1;
    checkOutput("abort_pc", dut.pc, 32'd0);
    checkOutput("abort_result", result, 32'd0);
    @(negedge clk);
    checkOutput("abort_valid1", {31'd0, dut.cache_unit.valid[1]}, 32'd0);
    pushExpect("re_result",  1, S_RESULT, 32'd97);
    pushExpect("re_miss",    1, S_MISS,   32'd1);
    pushExpect("re_valid1",  2, S_VALID1, 32'd1);
    pushExpect("re_load",    3, S_RESULT, 32'd1234);
    pushExpect("re_pc",      3, S_PC,     32'd8);
    releaseReset();
    runScoreboard(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
